alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream front-end for the serial 8-bit alu. It accepts whole commands (op, A, B) over a valid/ready
//  port and buffers them in a small FIFO. It drives the alu's BEGIN/op_code/inbus operand protocol, waits
//  for END, captures outbus and presents the result on a valid/ready output. Commands and results stay in order.
// PARAMETERS
//  FIFO_DEPTH      4   command FIFO entries (power of 2, >=2)
//  DATA_W          8   operand/result width; must equal alu inbus/outbus width
//  TIMEOUT_CYCLES  64  WAIT_END cycle limit (used only with ALU_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2       alu op_code (00 add, 01 sub, 10 mul, 11 div)
//  cmd_a        in   DATA_W  first operand
//  cmd_b        in   DATA_W  second operand
//  res_valid    out  1       result available
//  res_ready    in   1       result consumed when res_valid & res_ready
//  res_data     out  DATA_W  alu result (captured outbus)
//  res_err      out  1       result produced by timeout abort
//  alu_begin    out  1       to alu BEGIN
//  alu_op_code  out  2       to alu op_code
//  alu_inbus    out  DATA_W  to alu inbus
//  alu_outbus   in   DATA_W  from alu outbus
//  alu_end      in   1       from alu END
//  busy         out  1       state != IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, counters 0. Outputs: cmd_ready=1, res_valid=0, res_data=0, res_err=0,
//    alu_begin=0, alu_op_code=0, alu_inbus=0, busy=0. Reset during any state abandons the operation in flight.
//  - FIFO: cmd_ready = !full; there is no bypass path when full. A push and a pop in the same cycle leave the
//    count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - FSM (registered outputs):
//    IDLE:     if FIFO non-empty, pop the head into op/a/b registers and go to LOAD_A.
//    LOAD_A:   alu_begin=1, alu_op_code=op, alu_inbus=a for exactly 2 cycles, then go to LOAD_B.
//    LOAD_B:   alu_begin=0, alu_inbus=b for 1 cycle, then go to WAIT_END.
//    WAIT_END: hold alu_inbus=b and alu_op_code=op. When alu_end=1, load res_data<=alu_outbus,
//              set res_valid=1 and res_err=0, then go to RESULT.
//    RESULT:   res_valid, res_data and res_err stay stable until res_ready=1, then go to IDLE.
//              No new pop happens in the handshake cycle.
//  - alu_end is ignored outside WAIT_END.
//  - Minimum latency from accepting a command into an empty FIFO to res_valid: 5 cycles plus alu time.
//  - alu_op_code and alu_inbus keep their last values in IDLE and RESULT. alu_begin is 0 outside LOAD_A.
//  - Arithmetic is done by the alu only. res_data is outbus truncated to DATA_W with no extension.
// CONFIGURATION
//  ALU_SEQ_TIMEOUT_EN defined:
//   - A watchdog counter clears on entry to WAIT_END and increments each cycle while in WAIT_END without alu_end.
//   - When it reaches TIMEOUT_CYCLES, the block sets res_data={DATA_W{1'b1}}, res_err=1, res_valid=1 and goes to RESULT.
//   - alu_end arriving in the timeout cycle takes priority and produces a normal result.
//  ALU_SEQ_TIMEOUT_EN undefined: no counter; WAIT_END waits indefinitely; res_err is tied to 0.
// TESTING
//  1. Push op=00, a=3, b=2 with an alu model
//     -> alu_begin=1 for 2 cycles with inbus=3, then inbus=2; res_data=5, res_err=0.
//  2. Push 5 commands back-to-back with res_ready=0
//     -> cmd_ready=0 after the 5th is accepted.
//     Then raise res_ready -> results appear in push order: 3+2=5, 7-3=4, 7*3=21, 9/3=3, 1+1=2.
//  3. Hold res_ready=0 for 10 cycles in RESULT
//     -> res_valid and res_data stay stable; alu_begin stays 0.
//  4. Assert reset in WAIT_END with 2 commands queued
//     -> next cycle res_valid=0, alu_begin=0, cmd_ready=1, busy=0, FIFO empty.
//  5. With ALU_SEQ_TIMEOUT_EN and the model never asserting END
//     -> after 64 cycles in WAIT_END: res_valid=1, res_data=8'hFF, res_err=1.
//     Without the macro: the block stays in WAIT_END.
//  6. Pulse alu_end in IDLE and in RESULT -> no state change and no extra result.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus sequencer driving the serial alu BEGIN/op_code/inbus protocol and returning results in order.
// Optional WAIT_END watchdog is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              alu_begin,
    output logic [1:0]        alu_op_code,
    output logic [DATA_W-1:0] alu_inbus,
    input  logic [DATA_W-1:0] alu_outbus,
    input  logic              alu_end,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Both ports transfer on a cycle where valid & ready are high at the rising edge; a producer
    // holds valid and its payload stable until that edge, and ready never depends on valid.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_LOAD_B   = 3'd2,
        S_WAIT_END = 3'd3,
        S_RESULT   = 3'd4
    } state_t;

    logic [1:0]        r_fifo_op [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_a  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_b  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_alu_begin;
    logic [1:0]        r_alu_op_code;
    logic [DATA_W-1:0] r_alu_inbus;
    logic [DATA_W-1:0] r_cmd_b;
    logic              r_load_cnt;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              w_alu_begin_nxt;
    logic [1:0]        w_alu_op_code_nxt;
    logic [DATA_W-1:0] w_alu_inbus_nxt;
    logic [DATA_W-1:0] w_cmd_b_nxt;
    logic              w_load_cnt_nxt;
    logic              w_res_valid_nxt;
    logic [DATA_W-1:0] w_res_data_nxt;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic              r_res_err;
    logic              w_res_err_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;
    logic              w_timeout;

    assign w_timeout = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign res_err   = r_res_err;
`else
    logic              w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign res_err      = 1'b0;
`endif

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr] <= cmd_op;
            r_fifo_a[r_wr_ptr]  <= cmd_a;
            r_fifo_b[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_alu_begin   <= 1'b0;
            r_alu_op_code <= '0;
            r_alu_inbus   <= '0;
            r_cmd_b       <= '0;
            r_load_cnt    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_res_err     <= 1'b0;
            r_wd          <= '0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_alu_begin   <= w_alu_begin_nxt;
            r_alu_op_code <= w_alu_op_code_nxt;
            r_alu_inbus   <= w_alu_inbus_nxt;
            r_cmd_b       <= w_cmd_b_nxt;
            r_load_cnt    <= w_load_cnt_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_data    <= w_res_data_nxt;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_res_err     <= w_res_err_nxt;
            r_wd          <= w_wd_nxt;
`endif
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty) w_next_state = S_LOAD_A;
            S_LOAD_A:   if (r_load_cnt) w_next_state = S_LOAD_B;
            S_LOAD_B:   w_next_state = S_WAIT_END;
            S_WAIT_END: begin
                if (alu_end) begin
                    w_next_state = S_RESULT;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next_state = S_RESULT;
                end
`endif
            end
            S_RESULT:   if (res_ready) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so each branch computes the value seen during the next state.
    always_comb begin
        w_alu_begin_nxt   = 1'b0;
        w_alu_op_code_nxt = r_alu_op_code;
        w_alu_inbus_nxt   = r_alu_inbus;
        w_cmd_b_nxt       = r_cmd_b;
        w_load_cnt_nxt    = 1'b0;
        w_res_valid_nxt   = r_res_valid;
        w_res_data_nxt    = r_res_data;
`ifdef ALU_SEQ_TIMEOUT_EN
        w_res_err_nxt     = r_res_err;
        w_wd_nxt          = r_wd;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_alu_begin_nxt   = 1'b1;
                    w_alu_op_code_nxt = r_fifo_op[r_rd_ptr];
                    w_alu_inbus_nxt   = r_fifo_a[r_rd_ptr];
                    w_cmd_b_nxt       = r_fifo_b[r_rd_ptr];
                end
            end
            S_LOAD_A: begin
                if (!r_load_cnt) begin
                    w_alu_begin_nxt = 1'b1;
                    w_load_cnt_nxt  = 1'b1;
                end else begin
                    w_alu_inbus_nxt = r_cmd_b;
                end
            end
            S_LOAD_B: begin
`ifdef ALU_SEQ_TIMEOUT_EN
                w_wd_nxt = '0;
`endif
            end
            S_WAIT_END: begin
                if (alu_end) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = alu_outbus;
`ifdef ALU_SEQ_TIMEOUT_EN
                    w_res_err_nxt   = 1'b0;
                end else if (w_timeout) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = {DATA_W{1'b1}};
                    w_res_err_nxt   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
`endif
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign alu_begin   = r_alu_begin;
    assign alu_op_code = r_alu_op_code;
    assign alu_inbus   = r_alu_inbus;
    assign busy        = (r_state != S_IDLE) | ~w_empty;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed commands, a serial alu model, and an in-order result scoreboard.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;
    logic       alu_begin;
    logic [1:0] alu_op_code;
    logic [7:0] alu_inbus;
    logic [7:0] alu_outbus = 8'd0;
    logic       alu_end = 1'b0;
    logic       busy;
    logic [2:0] dbg_state;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .DATA_W(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_end(alu_end), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    int         alu_lat = 1;
    bit         alu_hang = 1'b0;
    int         pulse_seq = 0;
    int         pulse_done = 0;
    int         m_begin_cnt = 0;
    int         m_wait = 0;
    bit         m_busy = 1'b0;
    logic [1:0] m_op = 2'd0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_err = 1'b0;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 8'd0) ? 8'hFF : a / b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // serial alu model and result scoreboard, both evaluated away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            m_begin_cnt = 0;
            m_busy      = 1'b0;
            alu_end     = 1'b0;
            prev_valid  = 1'b0;
            pulse_done  = pulse_seq;
        end else begin
            alu_end    = 1'b0;
            alu_outbus = 8'hA5;
            if (alu_begin) begin
                if (m_begin_cnt != 0) chk("inbus_hold_a", 32'(alu_inbus), 32'(m_a));
                m_a = alu_inbus;
                m_op = alu_op_code;
                m_begin_cnt++;
            end else if (m_begin_cnt != 0) begin
                chk("begin_len", 32'(m_begin_cnt), 32'd2);
                m_b = alu_inbus;
                m_begin_cnt = 0;
                m_busy = !alu_hang;
                m_wait = alu_lat;
            end else if (m_busy) begin
                m_wait--;
                if (m_wait <= 0) begin
                    alu_end    = 1'b1;
                    alu_outbus = alu_f(m_op, m_a, m_b);
                    m_busy     = 1'b0;
                end
            end
            if (pulse_seq != pulse_done) begin
                alu_end    = 1'b1;
                alu_outbus = 8'h5A;
                pulse_done = pulse_seq;
            end

            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_data", 32'(res_data), 32'(prev_data));
                chk("hold_err", 32'(res_err), 32'(prev_err));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got %0h expected none", {res_err, res_data});
                end else begin
                    chk("result", 32'({res_err, res_data}), 32'(exp_q.pop_front()));
                    got_q.push_back({res_err, res_data});
                end
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_err   = res_err;
        end
    end

    // driver tasks
    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit timeout);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        while (!cmd_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!cmd_ready) begin
            chk("push_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(timeout ? 9'h1FF : {1'b0, alu_f(op, a, b)});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int g = 0;
        while (dbg_state != s && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reach_state", 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!res_valid && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reach_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    logic [1:0] t2_op  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] t2_a   [5] = '{8'd3, 8'd7, 8'd7, 8'd9, 8'd1};
    logic [7:0] t2_b   [5] = '{8'd2, 8'd3, 8'd3, 8'd3, 8'd1};
    logic [7:0] t2_lit [5] = '{8'd5, 8'd4, 8'd21, 8'd3, 8'd2};

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_alu_begin", 32'(alu_begin), 32'd0);
        chk("rst_alu_op_code", 32'(alu_op_code), 32'd0);
        chk("rst_alu_inbus", 32'(alu_inbus), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single add, minimum latency
        res_ready = 1'b1;
        alu_lat = 1;
        got_q.delete();
        push_cmd(2'd0, 8'd3, 8'd2, 1'b0);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd5);
        wait_drain();
        chk("t1_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("t1_result", 32'(got_q[0]), 32'h005);

        // five back-to-back commands with the result port stalled
        res_ready = 1'b0;
        alu_lat = 3;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_cmd(t2_op[i], t2_a[i], t2_b[i], 1'b0);
            if (i == 3) chk("ready_before_full", 32'(cmd_ready), 32'd1);
        end
        chk("full_ready", 32'(cmd_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("full_hold", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        wait_drain();
        chk("t2_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            chk("t2_order", 32'(got_q[i]), 32'({1'b0, t2_lit[i]}));
        end

        // stall in RESULT for 10 cycles
        res_ready = 1'b0;
        alu_lat = 2;
        got_q.delete();
        push_cmd(2'd2, 8'd12, 8'd11, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_valid", 32'(res_valid), 32'd1);
            chk("t3_data", 32'(res_data), 32'h84);
            chk("t3_begin", 32'(alu_begin), 32'd0);
        end
        res_ready = 1'b1;
        wait_drain();

        // stray alu_end in IDLE and in RESULT
        pulse_seq++;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_state", 32'(dbg_state), 32'd0);
        chk("t6_idle_valid", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        got_q.delete();
        push_cmd(2'd1, 8'd5, 8'd9, 1'b0);
        wait_valid();
        pulse_seq++;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_result_state", 32'(dbg_state), 32'd4);
        chk("t6_result_data", 32'(res_data), 32'hFC);
        res_ready = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("t6_count", 32'(got_q.size()), 32'd1);

        // reset during WAIT_END with two commands queued
        alu_lat = 40;
        got_q.delete();
        push_cmd(2'd0, 8'd1, 8'd2, 1'b0);
        push_cmd(2'd0, 8'd3, 8'd4, 1'b0);
        push_cmd(2'd0, 8'd5, 8'd6, 1'b0);
        wait_state(3'd3);
        pulse_reset();
        chk("t4_res_valid", 32'(res_valid), 32'd0);
        chk("t4_alu_begin", 32'(alu_begin), 32'd0);
        chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        chk("t4_idle_after", 32'(busy), 32'd0);
        chk("t4_no_result", 32'(got_q.size()), 32'd0);

        // alu never ends
        alu_lat = 1;
        alu_hang = 1'b1;
        got_q.delete();
        push_cmd(2'd3, 8'd9, 8'd3, 1'b1);
        wait_state(3'd3);
`ifdef ALU_SEQ_TIMEOUT_EN
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
        chk("timeout_err", 32'(res_err), 32'd1);
        wait_drain();
        if (got_q.size() > 0) chk("timeout_result", 32'(got_q[0]), 32'h1FF);
`else
        repeat (80) @(posedge clk);
        #1;
        chk("hang_state", 32'(dbg_state), 32'd3);
        chk("hang_valid", 32'(res_valid), 32'd0);
        chk("hang_busy", 32'(busy), 32'd1);
        pulse_reset();
`endif
        alu_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
